// File: rtl/i2c_pkg.sv
// i2c_pkg: shared FSM state, quarter indices, and bus constants for the I2C register master
package i2c_pkg;
  typedef enum logic [3:0] {
    IDLE, START, ADDR_W, ACK_A, REG, ACK_R, WDATA, ACK_D,
    RSTART, ADDR_R, ACK_A2, RDATA, MNACK, STOP
  } state_t;
  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ = 1'b1;
  localparam logic ACK = 1'b0;
  localparam logic NACK = 1'b1;
endpackage

// File: rtl/i2c_qtick.sv
// i2c_qtick: quarter-bit timebase (CLK_DIV cycles per quarter) with quarter index
// ports: clk/rst, run (clears counter when low), scl_oe/scl_in (stretch detect),
//        tick (last cycle of a quarter), q (current quarter 0..3)
// I2C_CLOCK_STRETCH_EN: hold the count in Q2/Q3 while a slave keeps SCL low
import i2c_pkg::*;
module i2c_qtick #(
  parameter int CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       scl_oe,
  input  logic       scl_in,
  output logic       tick,
  output logic [1:0] q
);
  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  logic [CW-1:0] cnt;
  logic hold;
`ifdef I2C_CLOCK_STRETCH_EN
  assign hold = q[1] && !scl_oe && !scl_in;
`else
  // fixed timing: scl_in is not observed
  assign hold = &{1'b0, scl_oe, scl_in};
`endif
  assign tick = run && !hold && cnt == CW'(CLK_DIV - 1);
  always_ff @(posedge clk)
    if (rst || !run) begin
      cnt <= '0;
      q   <= Q0;
    end else if (!hold) begin
      cnt <= tick ? '0 : cnt + 1'b1;
      q   <= tick ? q + 1'b1 : q;
    end
endmodule

// File: rtl/i2c_reg_master.sv
// i2c_reg_master: single-register I2C write/read master driving open-drain SCL/SDA enables
// ports: clk_50Mhz/reset (sync, active-high); start/rw/dev_addr/reg_addr/wdata request;
//        busy/done/ack_err/rdata status; sda_in/scl_in pin readback; sda_oe/scl_oe pull-low enables
// I2C_CLOCK_STRETCH_EN: honor slave clock stretching (see i2c_qtick)
import i2c_pkg::*;
module i2c_reg_master #(
  parameter int CLK_DIV = 125
) (
  input  logic       clk_50Mhz,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rdata,
  input  logic       sda_in,
  input  logic       scl_in,
  output logic       sda_oe,
  output logic       scl_oe
);
  state_t state, nxt;
  logic rw_r;
  logic [6:0] dev_r;
  logic [7:0] reg_r, wd_r, sh, tx;
  logic [2:0] bit_n;
  logic [1:0] q;
  logic tick, bit_end, samp, byte_end, is_tx, is_byte, is_ack, sda_d, scl_d;
  i2c_qtick #(.CLK_DIV(CLK_DIV)) u_qtick (
    .clk(clk_50Mhz), .rst(reset), .run(busy), .scl_oe(scl_oe), .scl_in(scl_in),
    .tick(tick), .q(q)
  );
  assign busy = state != IDLE;
  assign bit_end = tick && q == Q3;
  assign samp = tick && q == Q2;
  assign is_tx = state inside {ADDR_W, REG, WDATA, ADDR_R};
  assign is_byte = is_tx || state == RDATA;
  assign is_ack = state inside {ACK_A, ACK_R, ACK_D, ACK_A2};
  // bit_n walks 7..0 and wraps back to 7, so it is ready for the next byte
  assign byte_end = bit_end && bit_n == 3'd0;
  always_comb begin
    tx = state == ADDR_W ? {dev_r, 1'b0} : state == ADDR_R ? {dev_r, 1'b1} : state == REG ? reg_r : wd_r;
    sda_d = state inside {START, RSTART} ? q[1] : state == STOP ? q != Q3 : is_tx ? !tx[bit_n] : 1'b0;
    scl_d = state inside {IDLE, START} ? 1'b0 : state inside {RSTART, STOP} ? q == Q0 : !q[1];
    nxt = state;
    unique case (state)
      IDLE:    if (start) nxt = START;
      START:   if (bit_end) nxt = ADDR_W;
      ADDR_W:  if (byte_end) nxt = ACK_A;
      ACK_A:   if (bit_end) nxt = ack_err ? STOP : REG;
      REG:     if (byte_end) nxt = ACK_R;
      ACK_R:   if (bit_end) nxt = ack_err ? STOP : rw_r == RW_READ ? RSTART : WDATA;
      WDATA:   if (byte_end) nxt = ACK_D;
      ACK_D:   if (bit_end) nxt = STOP;
      RSTART:  if (bit_end) nxt = ADDR_R;
      ADDR_R:  if (byte_end) nxt = ACK_A2;
      ACK_A2:  if (bit_end) nxt = ack_err ? STOP : RDATA;
      RDATA:   if (byte_end) nxt = MNACK;
      MNACK:   if (bit_end) nxt = STOP;
      STOP:    if (bit_end) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_50Mhz)
    if (reset) begin
      state   <= IDLE;
      sda_oe  <= 1'b0;
      scl_oe  <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
      rdata   <= '0;
      bit_n   <= 3'd7;
    end else begin
      state  <= nxt;
      sda_oe <= sda_d;
      scl_oe <= scl_d;
      done   <= state == STOP && bit_end;
      if (state == IDLE && start) begin
        rw_r    <= rw;
        dev_r   <= dev_addr;
        reg_r   <= reg_addr;
        wd_r    <= wdata;
        ack_err <= 1'b0;
        bit_n   <= 3'd7;
      end
      if (samp && is_ack && sda_in == NACK) ack_err <= 1'b1;
      if (bit_end && is_byte) bit_n <= bit_n - 1'b1;
      if (samp && state == RDATA) sh <= {sh[6:0], sda_in};
      if (state == STOP && bit_end && rw_r == RW_READ && !ack_err) rdata <= sh;
    end
endmodule

// File: tb/tb_i2c_reg_master.sv
// tb_i2c_reg_master: scoreboard bench with an ACKing slave model at 0x50
module tb_i2c_reg_master;
  localparam int DIV = 4;
  localparam logic [6:0] SLV = 7'h50;
  localparam logic [11:0] EV_S = 12'h400;
  localparam logic [11:0] EV_P = 12'h800;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, rw = 1'b0;
  logic [6:0] dev_addr = '0;
  logic [7:0] reg_addr = '0, wdata = '0;
  logic busy, done, ack_err, sda_oe, scl_oe, sda_in, scl_in;
  logic [7:0] rdata;
  logic sdrv = 1'b0, shold = 1'b0, stretch_en = 1'b0;
  int n_checks = 0, n_fail = 0, done_cnt = 0;
  logic [11:0] expq[$];
  assign sda_in = !sda_oe && !sdrv;
  assign scl_in = !scl_oe && !shold;
  always #5 clk = ~clk;
  i2c_reg_master #(.CLK_DIV(DIV)) dut (
    .clk_50Mhz(clk), .reset(reset), .start(start), .rw(rw), .dev_addr(dev_addr),
    .reg_addr(reg_addr), .wdata(wdata), .busy(busy), .done(done), .ack_err(ack_err),
    .rdata(rdata), .sda_in(sda_in), .scl_in(scl_in), .sda_oe(sda_oe), .scl_oe(scl_oe)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic ev(input logic [11:0] v);
    logic [11:0] e;
    e = expq.size() == 0 ? 12'hFFF : expq.pop_front();
    check("bus_event", {20'd0, v}, {20'd0, e});
  endtask
  always @(negedge clk) if (done === 1'b1) done_cnt++;
  logic [7:0] sh = '0, txb = '0, rd_val = '0;
  int bitn = 0, byte_i = 0, sleft = 0;
  logic active = 1'b0, txm = 1'b0, pscl = 1'b1, psda = 1'b1;
  always @(negedge clk) begin
    logic scl, sda;
    scl = scl_in;
    sda = sda_in;
    if (shold && !scl_oe) begin
      if (sleft == 0) shold = 1'b0;
      else sleft--;
    end
    if (reset) begin
      active = 1'b0; sdrv = 1'b0; txm = 1'b0; bitn = 0;
    end else if (pscl && scl && psda && !sda) begin
      ev(EV_S); active = 1'b1; bitn = 0; byte_i = 0; txm = 1'b0;
    end else if (pscl && scl && !psda && sda) begin
      ev(EV_P); active = 1'b0; sdrv = 1'b0;
    end else if (active && !pscl && scl) begin
      if (bitn < 8) begin
        sh = {sh[6:0], sda}; bitn++;
      end else begin
        ev({3'b0, sda, sh});
        if (byte_i == 0 && sh[0] && !sda) begin txm = 1'b1; txb = rd_val; end
        else if (txm && sda) txm = 1'b0;
        bitn = 0; byte_i++;
      end
    end else if (active && pscl && !scl) begin
      if (bitn == 8) begin
        sdrv = !txm && (byte_i != 0 || sh[7:1] == SLV);
        if (stretch_en && byte_i == 1) begin shold = 1'b1; sleft = 20; end
      end else sdrv = txm && !txb[7-bitn];
    end
    pscl = scl;
    psda = sda;
  end
  task automatic txn(input logic r, input logic [6:0] d, input logic [7:0] ra, input logic [7:0] wd,
                     input logic [7:0] rv, input int quarters, input int extra, input logic exp_err,
                     input logic [7:0] exp_rd, input bit dbl);
    int n, d0;
    logic na;
    na = d != SLV;
    expq.push_back(EV_S);
    expq.push_back({3'b0, na, d, 1'b0});
    if (!na) begin
      expq.push_back({4'b0, ra});
      if (!r) expq.push_back({4'b0, wd});
      else begin
        expq.push_back(EV_S);
        expq.push_back({4'b0, d, 1'b1});
        expq.push_back({3'b0, 1'b1, rv});
      end
    end
    expq.push_back(EV_P);
    rd_val = rv;
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; rw = r; dev_addr = d; reg_addr = ra; wdata = wd;
    @(posedge clk); n = 1; #1; start = 1'b0;
    check("busy_set", {31'd0, busy}, 1);
    while (done !== 1'b1 && n < quarters * DIV + extra + 40) begin
      @(posedge clk); n++; #1;
      if (dbl) begin start = n == 40; dev_addr = 7'h51; rw = 1'b1; reg_addr = 8'hEE; end
    end
    check("latency", n, quarters * DIV + 1 + extra);
    check("ack_err", {31'd0, ack_err}, {31'd0, exp_err});
    check("rdata", {24'd0, rdata}, {24'd0, exp_rd});
    check("busy_at_done", {31'd0, busy}, 0);
    @(posedge clk); #1;
    check("done_pulse_width", {31'd0, done}, 0);
    check("done_count", done_cnt - d0, 1);
    check("queue_drained", expq.size(), 0);
  endtask
  initial begin
    int d0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sda_oe", {31'd0, sda_oe}, 0);
    check("rst_scl_oe", {31'd0, scl_oe}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_ack_err", {31'd0, ack_err}, 0);
    check("rst_rdata", {24'd0, rdata}, 0);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    txn(1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, 116, 0, 1'b0, 8'h00, 1'b0);
    txn(1'b1, 7'h50, 8'h22, 8'h00, 8'h3C, 156, 0, 1'b0, 8'h3C, 1'b0);
    txn(1'b1, 7'h51, 8'h33, 8'h00, 8'h99, 44, 0, 1'b1, 8'h3C, 1'b0);
    d0 = done_cnt;
    txn(1'b0, 7'h50, 8'h44, 8'h5A, 8'h00, 116, 0, 1'b0, 8'h3C, 1'b1);
    repeat (300) @(posedge clk);
    #1;
    check("ignored_start_done", done_cnt - d0, 1);
    check("ignored_start_idle", {31'd0, busy}, 0);
    check("ack_err_cleared", {31'd0, ack_err}, 0);
    expq.push_back(EV_S);
    expq.push_back(12'h0A0);
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; rw = 1'b0; dev_addr = 7'h50; reg_addr = 8'h10; wdata = 8'h5A;
    @(posedge clk); #1; start = 1'b0;
    repeat (200) @(posedge clk);
    #1; reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_sda_oe", {31'd0, sda_oe}, 0);
    check("midrst_scl_oe", {31'd0, scl_oe}, 0);
    check("midrst_busy", {31'd0, busy}, 0);
    check("midrst_ack_err", {31'd0, ack_err}, 0);
    reset = 1'b0;
    repeat (700) @(posedge clk);
    #1;
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_events", expq.size(), 0);
`ifdef I2C_CLOCK_STRETCH_EN
    stretch_en = 1'b1;
    txn(1'b0, 7'h50, 8'h10, 8'hC3, 8'h00, 116, 20, 1'b0, 8'h00, 1'b0);
    stretch_en = 1'b0;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_reg_master.md
# i2c_reg_master

Byte-level I2C master that drives the open-drain SCL/SDA enables of the board I2C pins directly from fabric, replacing the soft-core I2C peripheral for simple register access. A requester issues a single-register write or read (7-bit device address, 8-bit register, 8-bit data) with a start/busy/done handshake. The block sequences START, address, register, data, repeated START, ACK/NACK and STOP, and reports NACK errors. It sits between user logic and the top-level tri-state pin assignments, where SDA/SCL are driven low when the enable is 1 and high-Z otherwise.

## Interface
- CLK_DIV, 125: clk cycles per quarter SCL bit period; 125 gives 100 kHz at 50 MHz; minimum 2.
- clk_50Mhz  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request pulse; accepted only when busy=0.
- rw  in  1  0 = register write, 1 = register read.
- dev_addr  in  7  slave address.
- reg_addr  in  8  register index.
- wdata  in  8  write data.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle completion pulse.
- ack_err  out  1  a NACK was received; valid with done and held until the next accepted start.
- rdata  out  8  read result; updated only on successful read completion.
- sda_in, scl_in  in  1  pin readback.
- sda_oe, scl_oe  out  1  1 = pull the line low, 0 = release.

## Operation
- Reset values: sda_oe=0, scl_oe=0, busy=0, done=0, ack_err=0, rdata=0, FSM=IDLE.
- On start with busy=0, latch rw/dev_addr/reg_addr/wdata, clear ack_err, and set busy on the next cycle. A start while busy=1 is ignored.
- FSM states: IDLE, START, ADDR_W, ACK_A, REG, ACK_R, WDATA, ACK_D, RSTART, ADDR_R, ACK_A2, RDATA, MNACK, STOP.
- Write sequence: START, ADDR_W ({dev_addr,0}), ACK_A, REG, ACK_R, WDATA, ACK_D, STOP.
- Read sequence: START, ADDR_W, ACK_A, REG, ACK_R, RSTART, ADDR_R ({dev_addr,1}), ACK_A2, RDATA, MNACK (master sends 1), STOP.
- Data is sent and received MSB first.
- If any ACK sample reads SDA=1, set ack_err=1 and go directly to STOP. rdata is not updated in that case.
- Each bit is 4 quarters:
  - Q0: SCL low; set SDA on entry.
  - Q1: SCL low.
  - Q2: SCL released.
  - Q3: SCL released.
  - SDA is sampled at the end of Q2. SDA is released during ACK and RDATA bits.
- START (from bus idle): Q0–Q1 both lines released; Q2–Q3 SDA low, SCL released.
- RSTART: Q0 SCL low with SDA released; Q1 SCL released; Q2–Q3 SDA low.
- STOP: Q0 SCL low with SDA low; Q1–Q2 SCL released with SDA low; Q3 SDA released.
- After STOP Q3 ends, pulse done and drop busy in the same cycle.

## Timing
- The quarter counter counts 0..CLK_DIV-1. A quarter ends on terminal count.
- Quarter totals:
  - Write: 4 + 27×4 + 4 = 116 quarters (14 500 cycles at default).
  - Read: 4 + 18×4 + 4 + 9×4 + 9×4 + 4 = 156 quarters.
  - NACK on address: 44 quarters.
- Latency from accepted start to done = quarters×CLK_DIV + 1 cycle.
- The oe outputs are registered and change one cycle after a quarter boundary.
- Reset mid-transaction: both oe outputs release on the next edge, the FSM returns to IDLE, no done pulse, and ack_err=0.

## Configuration
- I2C_CLOCK_STRETCH_EN defined: during Q2/Q3 the quarter counter holds while scl_oe=0 and scl_in=0, honoring slave clock stretching.
- Undefined: scl_in is ignored and timing is fixed exactly as above.

## Structure
- Package i2c_pkg contains:
  - the FSM state enum;
  - quarter index constants Q0–Q3;
  - RW_WRITE/RW_READ;
  - ACK=0 and NACK=1.
- Sub-module i2c_qtick: quarter counter, terminal-count tick, quarter index, and the stretch hold under the macro.

## Test plan
- CLK_DIV=4 throughout, with an ACKing slave model at 0x50.
- Write dev 0x50, reg 0x10, data 0xA5:
  - the bit stream on SDA is 0xA0, 0x10, 0xA5 with an ACK after each byte;
  - done fires 116×4+1 cycles after start;
  - ack_err=0.
- Read dev 0x50, reg 0x22 with the slave returning 0x3C:
  - RSTART occurs, followed by 0xA1;
  - the master NACKs the data byte;
  - rdata=0x3C; done fires at 156×4+1 cycles.
- Address 0x51 (no slave): ACK_A samples 1, STOP follows, ack_err=1, done at 44×4+1 cycles, rdata is unchanged.
- A second start pulse while busy is ignored; exactly one done and one transaction appear on the bus.
- Assert reset in the middle of REG: the next cycle sda_oe=0, scl_oe=0, busy=0, and no done pulse follows.
- With I2C_CLOCK_STRETCH_EN, the slave holds SCL low for 20 cycles in ACK_R: completion is delayed by exactly 20 cycles and the data is still correct.
